// File: rtl/reset_seq.sv
// Purpose : board reset sequencer; drives PORESET/HRESET in order after power-up, reset request or watchdog.
// Latency : request edge reaches the FSM 3 clk after the input rises, so POR is entered on edge 4.
// Backpress: none; request edges that arrive outside RUN are dropped, never queued.
//
// Ports:
//   clk, rst_n        - system clock, async active-low reset
//   ce                - slow tick; sequence counters advance only when high
//   pwr_ok            - power good (async, active-high)
//   reset_req         - reset request from the upstream latch (async, active-high)
//   wdt_req           - watchdog reset request (async, active-high)
//   poreset_n         - SoC power-on reset, active-low, registered
//   hreset_n          - SoC hard reset, active-low, registered
//   in_reset          - high whenever the sequencer is not in RUN, registered
//   cause[1:0]        - last reset source: 00 power-on, 01 reset_req, 10 watchdog
module reset_seq #(
    parameter logic [7:0] POR_TICKS  = 8'd20,
    parameter logic [7:0] HRST_TICKS = 8'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       pwr_ok,
    input  logic       reset_req,
    input  logic       wdt_req,
    output logic       poreset_n,
    output logic       hreset_n,
    output logic       in_reset,
    output logic [1:0] cause
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_POR  = 2'd1,
        S_HRST = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_REQ = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // Synchronisers and edge detectors
    logic r_pwr_m, r_pwr_s;
    logic r_req_m, r_req_s, r_req_d, r_req_edge;
    logic r_wdt_m, r_wdt_s, r_wdt_d, r_wdt_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwr_m    <= 1'b0;
            r_pwr_s    <= 1'b0;
            r_req_m    <= 1'b0;
            r_req_s    <= 1'b0;
            r_req_d    <= 1'b0;
            r_req_edge <= 1'b0;
            r_wdt_m    <= 1'b0;
            r_wdt_s    <= 1'b0;
            r_wdt_d    <= 1'b0;
            r_wdt_edge <= 1'b0;
        end else begin
            r_pwr_m    <= pwr_ok;
            r_pwr_s    <= r_pwr_m;
            r_req_m    <= reset_req;
            r_req_s    <= r_req_m;
            r_req_d    <= r_req_s;
            // Registered single-cycle pulse on a synchronised rising edge
            r_req_edge <= r_req_s & ~r_req_d;
            r_wdt_m    <= wdt_req;
            r_wdt_s    <= r_wdt_m;
            r_wdt_d    <= r_wdt_s;
            r_wdt_edge <= r_wdt_s & ~r_wdt_d;
        end
    end

    // FSM state and registered outputs
    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_cause;
    logic       r_poreset_n, r_hreset_n, r_in_reset;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] w_cause_nxt;
    logic       w_poreset_n_nxt, w_hreset_n_nxt, w_in_reset_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_OFF;
            r_cnt       <= 8'd0;
            r_cause     <= CAUSE_POR;
            r_poreset_n <= 1'b0;
            r_hreset_n  <= 1'b0;
            r_in_reset  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cause     <= w_cause_nxt;
            r_poreset_n <= w_poreset_n_nxt;
            r_hreset_n  <= w_hreset_n_nxt;
            r_in_reset  <= w_in_reset_nxt;
        end
    end

    // Next-state logic. Power loss overrides everything; the exit compare
    // is evaluated every clk so a tick count of zero still costs one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        if (!r_pwr_s) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt = S_POR;
                    w_cnt_nxt   = 8'd0;
                    w_cause_nxt = CAUSE_POR;
                end
                S_POR: begin
                    if (r_cnt == POR_TICKS) begin
                        w_state_nxt = S_HRST;
                        w_cnt_nxt   = 8'd0;
                    end else if (ce) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                S_HRST: begin
                    if (r_cnt == HRST_TICKS) begin
                        w_state_nxt = S_RUN;
                    end else if (ce) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    if (r_wdt_edge) begin
                        w_state_nxt = S_POR;
                        w_cnt_nxt   = 8'd0;
                        w_cause_nxt = CAUSE_WDT;
                    end else if (r_req_edge) begin
                        w_state_nxt = S_POR;
                        w_cnt_nxt   = 8'd0;
                        w_cause_nxt = CAUSE_REQ;
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so pins move on the same edge as the state
    always_comb begin
        w_poreset_n_nxt = (w_state_nxt == S_HRST) || (w_state_nxt == S_RUN);
        w_hreset_n_nxt  = (w_state_nxt == S_RUN);
        w_in_reset_nxt  = (w_state_nxt != S_RUN);
    end

    assign poreset_n = r_poreset_n;
    assign hreset_n  = r_hreset_n;
    assign in_reset  = r_in_reset;
    assign cause     = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// Purpose : self-checking bench for reset_seq against a tick-budget reference model.
// Latency : model tracks input sample history to reproduce synchroniser delays.
// Backpress: not applicable.
module tb_reset_seq;

    localparam logic [7:0] POR_T  = 8'd4;
    localparam logic [7:0] HRST_T = 8'd2;

    logic       clk = 1'b0;
    logic       rst_n, ce, pwr_ok, reset_req, wdt_req;
    logic       poreset_n, hreset_n, in_reset;
    logic [1:0] cause;

    reset_seq #(.POR_TICKS(POR_T), .HRST_TICKS(HRST_T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .pwr_ok    (pwr_ok),
        .reset_req (reset_req),
        .wdt_req   (wdt_req),
        .poreset_n (poreset_n),
        .hreset_n  (hreset_n),
        .in_reset  (in_reset),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase of the sequence plus ticks still owed in it.
    localparam int M_OFF = 0, M_POR = 1, M_HRST = 2, M_RUN = 3;
    int       m_phase;
    int       m_left;
    int       m_cause;
    bit       p_h[$], r_h[$], w_h[$];   // input samples, index 0 = previous edge

    int por_cnt, hr_cnt;                // observed cycles with both low / only hreset low

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = M_OFF;
        m_left  = 0;
        m_cause = 0;
        p_h = '{0, 0, 0, 0};
        r_h = '{0, 0, 0, 0};
        w_h = '{0, 0, 0, 0};
    endtask

    // One clock edge. pwr_ok is seen two edges late; a request edge is acted on
    // three edges after the first high sample.
    task automatic model_edge();
        bit ps, er, ew;
        ps = p_h[1];
        er = r_h[2] && !r_h[3];
        ew = w_h[2] && !w_h[3];
        if (!ps) begin
            m_phase = M_OFF;
        end else if (m_phase == M_OFF) begin
            m_phase = M_POR; m_left = int'(POR_T); m_cause = 0;
        end else if (m_phase == M_POR) begin
            if (m_left == 0) begin m_phase = M_HRST; m_left = int'(HRST_T); end
            else if (ce) m_left--;
        end else if (m_phase == M_HRST) begin
            if (m_left == 0) m_phase = M_RUN;
            else if (ce) m_left--;
        end else begin
            if (ew)      begin m_phase = M_POR; m_left = int'(POR_T); m_cause = 2; end
            else if (er) begin m_phase = M_POR; m_left = int'(POR_T); m_cause = 1; end
        end
        p_h.push_front(pwr_ok);    p_h.pop_back();
        r_h.push_front(reset_req); r_h.pop_back();
        w_h.push_front(wdt_req);   w_h.pop_back();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".poreset_n"}, {7'd0, poreset_n}, {7'd0, 1'(m_phase == M_HRST || m_phase == M_RUN)});
        chk({tag, ".hreset_n"},  {7'd0, hreset_n},  {7'd0, 1'(m_phase == M_RUN)});
        chk({tag, ".in_reset"},  {7'd0, in_reset},  {7'd0, 1'(m_phase != M_RUN)});
        chk({tag, ".cause"},     {6'd0, cause},     8'(m_cause));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cyc");
        if (poreset_n === 1'b0 && hreset_n === 1'b0) por_cnt++;
        if (poreset_n === 1'b1 && hreset_n === 1'b0) hr_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        por_cnt = 0;
        hr_cnt  = 0;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; pwr_ok = 1'b0; reset_req = 1'b0; wdt_req = 1'b0;
        model_reset();
        clr();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // Power-up
        pwr_ok = 1'b1;
        run(25);
        chk("pwrup_cause", {6'd0, cause}, 8'd0);

        // Reset request held high: exactly one sequence
        clr();
        reset_req = 1'b1;
        run(20);
        reset_req = 1'b0;
        run(10);
        chk("req_por_len", 8'(por_cnt), 8'd5);
        chk("req_hr_len",  8'(hr_cnt),  8'd3);
        chk("req_cause", {6'd0, cause}, 8'd1);

        // Simultaneous watchdog and request: watchdog wins
        clr();
        reset_req = 1'b1; wdt_req = 1'b1;
        run(15);
        reset_req = 1'b0; wdt_req = 1'b0;
        run(3);
        chk("both_cause", {6'd0, cause}, 8'd2);
        chk("both_por_len", 8'(por_cnt), 8'd5);

        // Request edge landing while in HRST is dropped
        clr();
        wdt_req = 1'b1;
        run(7);
        reset_req = 1'b1;
        run(3);
        reset_req = 1'b0; wdt_req = 1'b0;
        run(12);
        chk("hrst_req_cause", {6'd0, cause}, 8'd2);
        chk("hrst_req_once", 8'(por_cnt), 8'd5);
        chk("hrst_req_run", {7'd0, in_reset}, 8'd0);

        // Power loss mid-POR, then restore
        reset_req = 1'b1;
        run(5);
        pwr_ok = 1'b0;
        run(3);
        chk("pwrdrop_off", {7'd0, poreset_n}, 8'd0);
        reset_req = 1'b0;
        run(2);
        pwr_ok = 1'b1;
        run(20);
        chk("pwrdrop_cause", {6'd0, cause}, 8'd0);
        chk("pwrdrop_run", {7'd0, in_reset}, 8'd0);

        // ce one cycle in four; exit on the clk after the last needed tick
        clr();
        reset_req = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ce = (i % 4 == 0);
            step();
        end
        reset_req = 1'b0;
        ce = 1'b1;
        chk("ce_por_win", 8'(por_cnt >= 14 && por_cnt <= 17), 8'd1);
        chk("ce_hr_win",  8'(hr_cnt >= 6 && hr_cnt <= 9), 8'd1);
        run(3);

        // Asynchronous reset in RUN takes effect without a clock edge
        chk("pre_arst_run", {7'd0, in_reset}, 8'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        #2;
        rst_n = 1'b1;
        run(20);
        chk("arst_rerun", {7'd0, in_reset}, 8'd0);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            ce = ($urandom_range(0, 2) == 0);
            if (pwr_ok) begin
                if ($urandom_range(0, 79) == 0) pwr_ok = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                pwr_ok = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) reset_req = ~reset_req;
            if ($urandom_range(0, 14) == 0) wdt_req = ~wdt_req;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
